// File: rtl/dpram_port_arbiter.sv
// Round-robin sharing of dual-port RAM port A between the CPU data bus
// (requester 0) and the DMA/loader engine (requester 1).
module dpram_port_arbiter #(
  parameter int adr_width = 13,
  parameter int dat_width = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 m0_req,
  input  logic                 m0_we,
  input  logic [adr_width-1:0] m0_adr,
  input  logic [dat_width-1:0] m0_wdat,
  output logic                 m0_ack,
  output logic [dat_width-1:0] m0_rdat,
  input  logic                 m1_req,
  input  logic                 m1_we,
  input  logic [adr_width-1:0] m1_adr,
  input  logic [dat_width-1:0] m1_wdat,
  output logic                 m1_ack,
  output logic [dat_width-1:0] m1_rdat,
  output logic                 busy,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [adr_width-1:0] ram_adr,
  output logic [dat_width-1:0] ram_wdat,
  input  logic [dat_width-1:0] ram_rdat
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  state_t state;

  // last: requester granted most recently
  // owner: requester of the transaction in flight
  logic last;
  logic owner;

  logic                 pick1;
  logic                 sel_we;
  logic [adr_width-1:0] sel_adr;
  logic [dat_width-1:0] sel_wdat;

  // Winner select: a tie goes to the requester not granted last
  always_comb begin
    pick1 = 1'b0;
    unique case (1'b1)
      m0_req & m1_req:  pick1 = ~last;
      m1_req & ~m0_req: pick1 = 1'b1;
      default:          pick1 = 1'b0;
    endcase
  end

  // Mux the winner's access fields toward the port registers
  always_comb begin
    sel_we   = m0_we;
    sel_adr  = m0_adr;
    sel_wdat = m0_wdat;
    if (pick1) begin
      sel_we   = m1_we;
      sel_adr  = m1_adr;
      sel_wdat = m1_wdat;
    end
  end

  // Transaction sequencer with registered port A and ack outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last     <= 1'b1;
      owner    <= 1'b0;
      busy     <= 1'b0;
      ram_en   <= 1'b0;
      ram_we   <= 1'b0;
      ram_adr  <= '0;
      ram_wdat <= '0;
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (m0_req | m1_req) begin
            state    <= ISSUE;
            busy     <= 1'b1;
            owner    <= pick1;
            last     <= pick1;
            ram_en   <= 1'b1;
            ram_we   <= sel_we;
            ram_adr  <= sel_adr;
            ram_wdat <= sel_wdat;
          end
        end
        ISSUE: begin
          state  <= RESP;
          ram_en <= 1'b0;
          ram_we <= 1'b0;
          m0_ack <= ~owner;
          m1_ack <= owner;
        end
        RESP: begin
          state  <= IDLE;
          busy   <= 1'b0;
          m0_ack <= 1'b0;
          m1_ack <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          ram_en <= 1'b0;
          ram_we <= 1'b0;
          m0_ack <= 1'b0;
          m1_ack <= 1'b0;
        end
      endcase
    end
  end

  // RAM output is registered; only the acked requester consumes it
  assign m0_rdat = ram_rdat;
  assign m1_rdat = ram_rdat;

endmodule
